// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Fetch-side instruction queue. Walks the PC, fetches words from instruction
//   memory over a req/ack handshake with at most one request outstanding,
//   buffers {pc, word} pairs in a DEPTH-entry FIFO and presents the head to the
//   ID stage with valid/ready. A redirect flushes the FIFO and restarts fetch at
//   the new PC; a fetch already in flight is drained and its data discarded.
//
//   Ports
//     clk, reset           clock (rising edge), async active-low reset
//     imem_req/imem_addr   fetch request and word address (held until ack)
//     imem_ack/imem_rdata  completion strobe and returned instruction word
//     redirect/redirect_pc flush and restart fetch at redirect_pc
//     id_valid/id_ready    handshake towards the ID stage
//     id_inst/id_pc        head instruction and its PC
//     id_opcode/id_funct   id_inst[31:26] / id_inst[5:0]
//
//   Build option
//     IFQ_BYPASS_EN  when defined, an acked word arriving while the FIFO is
//                    empty and ID is ready goes straight to ID in the same
//                    cycle and is not written to the FIFO.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | FIFO full, no request issued
//   REQ   | request outstanding at fetchPc
//   DRAIN | redirect hit an in-flight fetch; wait for its ack, drop data
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} stateE;

    stateE         state, stateNext;
    logic [31:0]   fetchPc, fetchPcNext;
    logic [31:0]   targetPc, targetPcNext;
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] count, countNext;
    logic [63:0]   mem [DEPTH];
    logic [63:0]   head;
    logic          hasData, push, pop, bypass;

    always_comb begin
        bypass = 1'b0;
`ifdef IFQ_BYPASS_EN
        bypass = reset && (count == '0) && (state == REQ) && imem_ack && id_ready && !redirect;
`endif
        hasData   = (count != '0);
        head      = mem[rdPtr];
        id_valid  = hasData || bypass;
        pop       = hasData && id_ready && !redirect;
        push      = (state == REQ) && imem_ack && !redirect && !bypass;
        countNext = count + CW'(push) - CW'(pop);

        id_inst   = bypass ? imem_rdata : (hasData ? head[31:0]  : 32'h0);
        id_pc     = bypass ? fetchPc    : (hasData ? head[63:32] : 32'h0);
        id_opcode = id_inst[31:26];
        id_funct  = id_inst[5:0];

        // Gated by reset so the request drops the moment reset asserts.
        imem_req  = reset && ((state == REQ) || (state == DRAIN));
        imem_addr = fetchPc;
    end

    // In DRAIN fetchPc keeps the outstanding address so imem_addr stays
    // stable; the redirect target waits in targetPc until the ack arrives.
    always_comb begin
        stateNext    = state;
        fetchPcNext  = fetchPc;
        targetPcNext = targetPc;
        if (redirect) begin
            targetPcNext = redirect_pc;
            if ((state == IDLE) || imem_ack) begin
                stateNext   = REQ;
                fetchPcNext = redirect_pc;
            end else begin
                stateNext = DRAIN;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (countNext < FULL) stateNext = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        fetchPcNext = fetchPc + 32'd4;
                        if (countNext == FULL) stateNext = IDLE;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        fetchPcNext = targetPc;
                        stateNext   = REQ;
                    end
                end
                default: stateNext = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= REQ;
            fetchPc  <= PC_RESET;
            targetPc <= PC_RESET;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
        end else begin
            state    <= stateNext;
            fetchPc  <= fetchPcNext;
            targetPc <= targetPcNext;
            if (redirect) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + PW'(1);
                if (pop)  rdPtr <= rdPtr + PW'(1);
                count <= countNext;
            end
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= {fetchPc, imem_rdata};
    end
endmodule
